// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared defaults and FSM state encoding for the elevator call scheduler
package elevator_pkg;

   localparam int NUM_FLOORS_DEF = 10;
   localparam int FLOOR_W_DEF    = 4;

   typedef enum logic [1:0] {
      IDLE        = 2'b00,
      SELECT      = 2'b01,
      DISPATCH    = 2'b10,
      WAIT_ARRIVE = 2'b11
   } state_t;

endpackage

// File: rtl/scan_next_floor.sv
// rtl/scan_next_floor.sv - combinational SCAN pick of the next pending floor
module scan_next_floor
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = NUM_FLOORS_DEF,
   parameter int FLOOR_W    = FLOOR_W_DEF
) (
   input  logic [NUM_FLOORS-1:0] pending,
   input  logic [FLOOR_W-1:0]    car_floor,
   input  logic                  dir_up,
   output logic                  found,
   output logic [FLOOR_W-1:0]    floor,
   output logic                  new_dir
);

   logic               found_above;
   logic               found_below;
   logic [FLOOR_W-1:0] nearest_above;
   logic [FLOOR_W-1:0] nearest_below;

   // Nearest pending floor strictly above and strictly below the car
   always_comb begin
      found_above   = 1'b0;
      found_below   = 1'b0;
      nearest_above = '0;
      nearest_below = '0;
      // descending walk: the last hit is the lowest floor above the car
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (pending[i] && (FLOOR_W'(i) > car_floor)) begin
            found_above   = 1'b1;
            nearest_above = FLOOR_W'(i);
         end
      end
      // ascending walk: the last hit is the highest floor below the car
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending[i] && (FLOOR_W'(i) < car_floor)) begin
            found_below   = 1'b1;
            nearest_below = FLOOR_W'(i);
         end
      end
   end

   // Keep sweeping in the current direction, reverse only when that side is empty
   always_comb begin
      found   = 1'b0;
      floor   = '0;
      new_dir = dir_up;
      if (dir_up) begin
         if (found_above) begin
            found = 1'b1; floor = nearest_above; new_dir = 1'b1;
         end else if (found_below) begin
            found = 1'b1; floor = nearest_below; new_dir = 1'b0;
         end
      end else begin
         if (found_below) begin
            found = 1'b1; floor = nearest_below; new_dir = 1'b0;
         end else if (found_above) begin
            found = 1'b1; floor = nearest_above; new_dir = 1'b1;
         end
      end
   end

endmodule

// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - SCAN call scheduler; SCHED_TIMEOUT_EN adds an arrival watchdog
module elevator_call_scheduler
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS     = NUM_FLOORS_DEF,
   parameter int FLOOR_W        = FLOOR_W_DEF,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] call_req,
   input  logic [FLOOR_W-1:0]    car_floor,
   input  logic                  arrived,
   input  logic                  target_ready,
   output logic                  target_valid,
   output logic [FLOOR_W-1:0]    target_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  dir_up,
   output logic                  busy,
   output logic                  fault
);

   state_t                  state;
   state_t                  state_next;
   logic [NUM_FLOORS-1:0]   car_hot;
   logic [NUM_FLOORS-1:0]   pending_next;
   logic                    sel_found;
   logic [FLOOR_W-1:0]      sel_floor;
   logic                    sel_dir;
   logic                    timeout;

   // One-hot of the car position; a floor number beyond the shaft matches nothing
   always_comb begin
      car_hot = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         car_hot[i] = (car_floor == FLOOR_W'(i));
      end
   end

   // Latch new calls (dropping the car's own floor while idle); arrival clear has priority
   always_comb begin
      pending_next = pending | (call_req & ~((state == IDLE) ? car_hot : '0));
      if (arrived) begin
         pending_next = pending_next & ~car_hot;
      end
   end

   scan_next_floor #(
      .NUM_FLOORS (NUM_FLOORS),
      .FLOOR_W    (FLOOR_W)
   ) u_scan (
      .pending   (pending),
      .car_floor (car_floor),
      .dir_up    (dir_up),
      .found     (sel_found),
      .floor     (sel_floor),
      .new_dir   (sel_dir)
   );

`ifdef SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wd_cnt;
   logic             fault_q;

   assign timeout = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign fault   = fault_q;

   // Watchdog counts cycles spent in WAIT_ARRIVE, restarting from zero on every entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
      end else if (state != WAIT_ARRIVE) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   // Single-cycle fault when the wait gives up without an arrival
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= (state == WAIT_ARRIVE) && !arrived && timeout;
      end
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout            = 1'b0;
   assign fault              = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state; an accepted dispatch is only left on arrival or watchdog expiry
   always_comb begin
      state_next = state;
      case (state)
         IDLE:        if (|pending) state_next = SELECT;
         SELECT:      state_next = sel_found ? DISPATCH : IDLE;
         DISPATCH:    if (target_ready) state_next = WAIT_ARRIVE;
         WAIT_ARRIVE: if (arrived || timeout) state_next = SELECT;
         default:     state_next = IDLE;
      endcase
   end

   // Pending calls, plus target and sweep direction captured only in SELECT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending      <= '0;
         target_floor <= '0;
         dir_up       <= 1'b1;
      end else begin
         pending <= pending_next;
         if ((state == SELECT) && sel_found) begin
            target_floor <= sel_floor;
            dir_up       <= sel_dir;
         end
      end
   end

   assign target_valid = (state == DISPATCH);
   assign busy         = (state != IDLE);

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb/tb_elevator_call_scheduler.sv - directed self-checking bench for elevator_call_scheduler
`timescale 1ns/1ps
module tb_elevator_call_scheduler;

   localparam int NF = 10;
   localparam int FW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NF-1:0] call_req;
   logic [FW-1:0] car_floor;
   logic          arrived;
   logic          target_ready;
   logic          target_valid;
   logic [FW-1:0] target_floor;
   logic [NF-1:0] pending;
   logic          dir_up;
   logic          busy;
   logic          fault;

   int checks   = 0;
   int failures = 0;

   elevator_call_scheduler #(
      .NUM_FLOORS     (NF),
      .FLOOR_W        (FW),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .call_req     (call_req),
      .car_floor    (car_floor),
      .arrived      (arrived),
      .target_ready (target_ready),
      .target_valid (target_valid),
      .target_floor (target_floor),
      .pending      (pending),
      .dir_up       (dir_up),
      .busy         (busy),
      .fault        (fault)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic accept();
      target_ready = 1'b1;
      tick();
      target_ready = 1'b0;
   endtask

   task automatic arrive(input logic [FW-1:0] f);
      car_floor = f;
      arrived   = 1'b1;
      tick();
      arrived   = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      call_req     = '0;
      car_floor    = '0;
      arrived      = 1'b0;
      target_ready = 1'b0;
      tick();
      tick();
      chk("rst_pending", 32'(pending), 32'h0);
      chk("rst_valid", 32'(target_valid), 32'h0);
      chk("rst_floor", 32'(target_floor), 32'h0);
      chk("rst_dir", 32'(dir_up), 32'h1);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      rst_n = 1'b1;

      // single call to floor 5 from floor 0
      call_req = 10'h020;
      tick();
      call_req = '0;
      chk("c5_pending", 32'(pending), 32'h020);
      chk("c5_idle", 32'(busy), 32'h0);
      tick();
      chk("c5_select_busy", 32'(busy), 32'h1);
      chk("c5_select_valid", 32'(target_valid), 32'h0);
      tick();
      chk("c5_valid", 32'(target_valid), 32'h1);
      chk("c5_floor", 32'(target_floor), 32'h5);
      accept();
      chk("c5_wait_valid", 32'(target_valid), 32'h0);
      chk("c5_wait_busy", 32'(busy), 32'h1);
      arrive(4'd5);
      chk("c5_cleared", 32'(pending), 32'h0);
      tick();
      chk("c5_back_idle", 32'(busy), 32'h0);

      // SCAN from floor 4 going up with calls at 2, 6, 8
      car_floor = 4'd4;
      call_req  = 10'h144;
      tick();
      call_req = '0;
      chk("scan_pending", 32'(pending), 32'h144);
      tick();
      tick();
      chk("scan_t1", 32'(target_floor), 32'h6);
      chk("scan_d1", 32'(dir_up), 32'h1);
      accept();
      arrive(4'd6);
      chk("scan_pend2", 32'(pending), 32'h104);
      tick();
      chk("scan_t2", 32'(target_floor), 32'h8);
      chk("scan_v2", 32'(target_valid), 32'h1);
      accept();
      arrive(4'd8);
      tick();
      chk("scan_t3", 32'(target_floor), 32'h2);
      chk("scan_d3", 32'(dir_up), 32'h0);
      accept();
      arrive(4'd2);
      tick();
      chk("scan_idle", 32'(busy), 32'h0);
      chk("scan_empty", 32'(pending), 32'h0);

      // held-off dispatch to floor 7; late calls latch without retargeting
      call_req = 10'h080;
      tick();
      call_req = '0;
      tick();
      tick();
      for (int i = 0; i < 20; i++) begin
         if (i == 5) call_req = 10'h200;
         if (i == 10) begin
            car_floor = 4'd4;
            call_req  = 10'h010;
            arrived   = 1'b1;
         end
         tick();
         call_req  = '0;
         arrived   = 1'b0;
         car_floor = 4'd2;
         chk("hold_valid", 32'(target_valid), 32'h1);
         chk("hold_floor", 32'(target_floor), 32'h7);
         if (i == 10) chk("clear_wins", 32'(pending[4]), 32'h0);
      end
      chk("hold_pending", 32'(pending), 32'h280);
      chk("hold_dir", 32'(dir_up), 32'h1);
      accept();
      chk("hold_accepted", 32'(target_valid), 32'h0);
      arrive(4'd7);
      tick();
      chk("next_target9", 32'(target_floor), 32'h9);
      accept();
      arrive(4'd9);
      tick();
      chk("idle_at9", 32'(busy), 32'h0);

      // arrival watchdog while waiting for floor 3
      call_req = 10'h008;
      tick();
      call_req = '0;
      tick();
      tick();
      chk("wd_target", 32'(target_floor), 32'h3);
      accept();
`ifdef SCHED_TIMEOUT_EN
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk("wd_fault", 32'(fault), (k == 16) ? 32'h1 : 32'h0);
      end
      tick();
      chk("wd_fault_pulse", 32'(fault), 32'h0);
      chk("wd_redispatch", 32'(target_valid), 32'h1);
      chk("wd_same_floor", 32'(target_floor), 32'h3);
      chk("wd_pending", 32'(pending), 32'h008);
      accept();
`else
      for (int k = 0; k < 40; k++) begin
         tick();
         chk("wd_no_fault", 32'(fault), 32'h0);
         chk("wd_still_wait", 32'(target_valid), 32'h0);
      end
      chk("wd_busy", 32'(busy), 32'h1);
`endif
      arrive(4'd3);
      tick();
      chk("idle_at3", 32'(busy), 32'h0);

      // asynchronous reset while waiting with calls 4..7 outstanding
      call_req = 10'h0F0;
      tick();
      call_req = '0;
      tick();
      tick();
      chk("pre_rst_target", 32'(target_floor), 32'h4);
      accept();
      chk("pre_rst_pending", 32'(pending), 32'h0F0);
      chk("pre_rst_busy", 32'(busy), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_pending", 32'(pending), 32'h0);
      chk("arst_valid", 32'(target_valid), 32'h0);
      chk("arst_floor", 32'(target_floor), 32'h0);
      chk("arst_dir", 32'(dir_up), 32'h1);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_fault", 32'(fault), 32'h0);
      tick();
      rst_n = 1'b1;

      // call at the idle car's own floor is dropped
      call_req = 10'h008;
      tick();
      call_req = '0;
      chk("own_floor_pending", 32'(pending), 32'h0);
      chk("own_floor_busy", 32'(busy), 32'h0);
      tick();
      chk("own_floor_busy2", 32'(busy), 32'h0);
      call_req = 10'h008;
      arrived  = 1'b1;
      tick();
      call_req = '0;
      arrived  = 1'b0;
      chk("own_floor_arrive", 32'(pending), 32'h0);
      tick();
      chk("own_floor_idle", 32'(busy), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
